// File: rtl/approx_mult_cfg_sweeper_if.sv
// Bundle between the configuration sweeper (master) and its environment:
// sweep control, multiplier drive/return, and the result-record handshake.
interface approx_mult_cfg_sweeper_if #(
  parameter int WIDTH       = 8,
  parameter int CFG_W       = 16,
  parameter int SAMPLE_LOG2 = 8
);
  logic                            start;
  logic [CFG_W-1:0]                cfg_first;
  logic [CFG_W-1:0]                cfg_last;
  logic [2*WIDTH-1:0]              seed;
  logic                            busy;
  logic                            done;
  logic [CFG_W-1:0]                mul_cfg;
  logic [WIDTH-1:0]                mul_a;
  logic [WIDTH-1:0]                mul_b;
  logic [2*WIDTH-1:0]              mul_p;
  logic                            res_valid;
  logic                            res_ready;
  logic [CFG_W-1:0]                res_cfg;
  logic [SAMPLE_LOG2:0]            res_err_cnt;
  logic [2*WIDTH+SAMPLE_LOG2-1:0]  res_ed_sum;
  logic [2*WIDTH-1:0]              res_ed_max;

  modport master (
    input  start, cfg_first, cfg_last, seed, mul_p, res_ready,
    output busy, done, mul_cfg, mul_a, mul_b,
           res_valid, res_cfg, res_err_cnt, res_ed_sum, res_ed_max
  );

  modport slave (
    output start, cfg_first, cfg_last, seed, mul_p, res_ready,
    input  busy, done, mul_cfg, mul_a, mul_b,
           res_valid, res_cfg, res_err_cnt, res_ed_sum, res_ed_max
  );
endinterface

// File: rtl/approx_mult_cfg_sweeper.sv
// Sweeps configuration words across an external approximate multiplier, driving
// a reproducible LFSR operand stream and reporting error statistics per config.
module approx_mult_cfg_sweeper #(
  parameter int               WIDTH       = 8,
  parameter int               CFG_W       = 16,
  parameter int               SAMPLE_LOG2 = 8,
  parameter logic [2*WIDTH-1:0] POLY      = 16'hB400
) (
  input logic                      clk,
  input logic                      rst_n,
  approx_mult_cfg_sweeper_if.master bus
);
  localparam int PW = 2 * WIDTH;
  localparam int SW = PW + SAMPLE_LOG2;
  localparam int EW = SAMPLE_LOG2 + 1;

  typedef enum logic [1:0] {IDLE, SETTLE, RUN, REPORT} state_t;

  state_t                 state_q, state_d;
  logic [CFG_W-1:0]       cfg_last_q, cfg_last_d;
  logic [CFG_W-1:0]       cur_cfg_q, cur_cfg_d;
  logic [PW-1:0]          seed_q, seed_d;
  logic [PW-1:0]          lfsr_q, lfsr_d;
  logic [SAMPLE_LOG2-1:0] cnt_q, cnt_d;
  logic [EW-1:0]          err_q, err_d;
  logic [SW-1:0]          sum_q, sum_d;
  logic [PW-1:0]          max_q, max_d;
  logic                   done_q, done_d;

  logic [PW-1:0] exact, ed, lfsr_step, seed_eff;

  always_comb begin
    exact     = PW'(bus.mul_a) * PW'(bus.mul_b);
    ed        = (exact >= bus.mul_p) ? (exact - bus.mul_p) : (bus.mul_p - exact);
    lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ POLY) : (lfsr_q >> 1);
    // An all-zero Galois LFSR never leaves zero, so substitute 1.
    seed_eff  = (bus.seed == '0) ? PW'(1) : bus.seed;
  end

  always_comb begin
    state_d    = state_q;
    cfg_last_d = cfg_last_q;
    cur_cfg_d  = cur_cfg_q;
    seed_d     = seed_q;
    lfsr_d     = lfsr_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    sum_d      = sum_q;
    max_d      = max_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          cfg_last_d = bus.cfg_last;
          cur_cfg_d  = bus.cfg_first;
          seed_d     = seed_eff;
          lfsr_d     = seed_eff;
          cnt_d      = '0;
          err_d      = '0;
          sum_d      = '0;
          max_d      = '0;
          state_d    = SETTLE;
        end
      end
      SETTLE: state_d = RUN;
      RUN: begin
        err_d  = err_q + EW'(ed != '0);
        sum_d  = sum_q + SW'(ed);
        max_d  = (ed > max_q) ? ed : max_q;
        lfsr_d = lfsr_step;
        cnt_d  = cnt_q + SAMPLE_LOG2'(1);
        if (cnt_q == '1) state_d = REPORT;
      end
      REPORT: begin
        if (bus.res_ready) begin
          if (cur_cfg_q == cfg_last_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            // Wraps naturally through all-ones to zero for descending ranges.
            cur_cfg_d = cur_cfg_q + CFG_W'(1);
            lfsr_d    = seed_q;
            cnt_d     = '0;
            err_d     = '0;
            sum_d     = '0;
            max_d     = '0;
            state_d   = SETTLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cfg_last_q <= '0;
      cur_cfg_q  <= '0;
      seed_q     <= '0;
      lfsr_q     <= '0;
      cnt_q      <= '0;
      err_q      <= '0;
      sum_q      <= '0;
      max_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_last_q <= cfg_last_d;
      cur_cfg_q  <= cur_cfg_d;
      seed_q     <= seed_d;
      lfsr_q     <= lfsr_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      sum_q      <= sum_d;
      max_q      <= max_d;
      done_q     <= done_d;
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.mul_cfg     = cur_cfg_q;
  assign bus.mul_a       = lfsr_q[WIDTH-1:0];
  assign bus.mul_b       = lfsr_q[PW-1:WIDTH];
  assign bus.res_valid   = (state_q == REPORT);
  assign bus.res_cfg     = cur_cfg_q;
  assign bus.res_err_cnt = err_q;
  assign bus.res_ed_sum  = sum_q;
  assign bus.res_ed_max  = max_q;
endmodule
